// File: rtl/screen_transition_ctl_pkg.sv
// Shared game/draw definitions: screen identifiers, fade limits and
// saturating fade-level arithmetic used by the transition controller.
package screen_transition_ctl_pkg;

  typedef enum logic [1:0] {
    SCREEN_START   = 2'd0,
    SCREEN_GK      = 2'd1,
    SCREEN_SHOOTER = 2'd2,
    SCREEN_END     = 2'd3
  } screen_t;

  localparam int unsigned LEVEL_W  = 4;
  localparam logic [3:0]  FADE_MAX = 4'd15;
  localparam logic [3:0]  FADE_MIN = 4'd0;

  // Darken by one step; a borrow into bit 4 means the result went below 0.
  function automatic logic [3:0] fade_dec(input logic [3:0] level, input logic [3:0] step);
    logic [4:0] diff;
    diff = {1'b0, level} - {1'b0, step};
    return diff[4] ? FADE_MIN : diff[3:0];
  endfunction

  // Brighten by one step; a carry into bit 4 means the result passed 15.
  function automatic logic [3:0] fade_inc(input logic [3:0] level, input logic [3:0] step);
    logic [4:0] sum;
    sum = {1'b0, level} + {1'b0, step};
    return sum[4] ? FADE_MAX : sum[3:0];
  endfunction

endpackage

// File: rtl/screen_transition_ctl_frame_tick.sv
// Frame-start detector and brightness-step divider.
//   clk, rst_n     : clock, async active-low reset
//   vsync_i        : vertical sync, rising edge = frame start
//   clr_i          : synchronous clear of the frame divider
//   frame_start_c  : combinational, high in the cycle vsync is first sampled high
//   step_tick_c    : combinational, frame start that completes FRAMES_PER_STEP frames
module screen_transition_ctl_frame_tick #(
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  input  logic clr_i,
  output logic frame_start_c,
  output logic step_tick_c
);

  localparam int unsigned CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  logic             vsync_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // armed_q masks the first cycle after reset so a vsync already high at
  // release is not mistaken for a rising edge.
  assign frame_start_c = vsync_i & ~vsync_q & armed_q;
  assign step_tick_c   = frame_start_c && (cnt_q == CNT_LAST);

  // Divider next value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (frame_start_c) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Edge-detect and divider registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vsync_q <= vsync_i;
      armed_q <= 1'b1;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/screen_transition_ctl.sv
// Frame-synchronous screen transition sequencer: fades the current screen to
// black, swaps the background select during a black frame, fades back in.
//   clk, rst_n   : pixel clock, async active-low reset
//   vsync        : vertical sync (rising edge = frame start)
//   screen_req   : requested screen (screen_t encoding)
//   screen_sel   : registered background mux select
//   fade_level   : registered brightness, 15 full .. 0 black
//   busy         : registered, high whenever not in SHOW
//   switch_done  : registered one-cycle pulse when a transition completes
module screen_transition_ctl #(
  parameter int unsigned FRAMES_PER_STEP = 2,
  parameter int unsigned FADE_STEP       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic [1:0] screen_req,
  output logic [1:0] screen_sel,
  output logic [3:0] fade_level,
  output logic       busy,
  output logic       switch_done
);

  import screen_transition_ctl_pkg::*;

  typedef enum logic [1:0] {
    ST_SHOW     = 2'd0,
    ST_FADE_OUT = 2'd1,
    ST_SWAP     = 2'd2,
    ST_FADE_IN  = 2'd3
  } ctl_state_t;

  localparam logic [LEVEL_W-1:0] STEP = LEVEL_W'(FADE_STEP);

  ctl_state_t         state_q, state_d;
  screen_t            sel_q, sel_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               frame_start_c;
  logic               step_tick_c;
  logic               cnt_clr_c;
  screen_t            req_c;

  assign req_c = screen_t'(screen_req);

  // Divider runs only inside a fade and restarts on every state change.
  assign cnt_clr_c = (state_d != state_q) ||
                     (state_q == ST_SHOW) || (state_q == ST_SWAP);

  screen_transition_ctl_frame_tick #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_frame_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (vsync),
    .clr_i        (cnt_clr_c),
    .frame_start_c(frame_start_c),
    .step_tick_c  (step_tick_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    level_d = level_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_SHOW: begin
        if (frame_start_c && (req_c != sel_q)) state_d = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (step_tick_c) begin
          level_d = fade_dec(level_q, STEP);
          if (level_d == FADE_MIN) state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        // Latest request wins; may equal the old screen.
        if (frame_start_c) begin
          sel_d   = req_c;
          state_d = ST_FADE_IN;
        end
      end
      ST_FADE_IN: begin
        if (step_tick_c) begin
          level_d = fade_inc(level_q, STEP);
          if (level_d == FADE_MAX) begin
            state_d = ST_SHOW;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_SHOW;
    endcase
    busy_d = (state_d != ST_SHOW);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHOW;
      sel_q   <= SCREEN_START;
      level_q <= FADE_MAX;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign screen_sel  = sel_q;
  assign fade_level  = level_q;
  assign busy        = busy_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_screen_transition_ctl.sv
// Directed scoreboard bench for screen_transition_ctl: default-parameter
// instance plus a FRAMES_PER_STEP=1 / FADE_STEP=4 instance.
module tb_screen_transition_ctl;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] lvl;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, rst_n6;
  logic       vsync, vsync6;
  logic [1:0] req, req6;
  logic [1:0] sel, sel6;
  logic [3:0] lvl, lvl6;
  logic       busy, busy6, done, done6;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  screen_transition_ctl dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .screen_req(req),
    .screen_sel(sel), .fade_level(lvl), .busy(busy), .switch_done(done)
  );

  screen_transition_ctl #(.FRAMES_PER_STEP(1), .FADE_STEP(4)) dut6 (
    .clk(clk), .rst_n(rst_n6), .vsync(vsync6), .screen_req(req6),
    .screen_sel(sel6), .fade_level(lvl6), .busy(busy6), .switch_done(done6)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".sel"},  8'(a.sel),  8'(e.sel));
    chk({tag, ".lvl"},  8'(a.lvl),  8'(e.lvl));
    chk({tag, ".busy"}, 8'(a.busy), 8'(e.busy));
    chk({tag, ".done"}, 8'(a.done), 8'(e.done));
  endtask

  function automatic exp_t obs(input bit six);
    return six ? exp_t'({sel6, lvl6, busy6, done6}) : exp_t'({sel, lvl, busy, done});
  endfunction

  // One vsync frame: rising edge, sample just after the capturing edge,
  // check the done pulse is gone one cycle later, then vsync low.
  task automatic frame(input bit six, input string tag);
    exp_t e;
    exp_t a;
    @(negedge clk);
    if (six) vsync6 = 1'b1; else vsync = 1'b1;
    @(posedge clk); #1;
    a = obs(six);
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk_all(tag, a, e);
    end
    @(posedge clk); #1;
    a = obs(six);
    chk({tag, ".done_width"}, 8'(a.done), 8'd0);
    repeat (2) @(negedge clk);
    if (six) vsync6 = 1'b0; else vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Default-parameter transition: req0 drives F0..F3, req_late from F4 on.
  task automatic run_default(input logic [1:0] old_sel, input logic [1:0] req0,
                             input logic [1:0] req_late, input int nframes, input string tag);
    logic [3:0] lvl_tab [14];
    exp_t e;
    lvl_tab = '{4'd15, 4'd15, 4'd10, 4'd10, 4'd5, 4'd5, 4'd0,
                4'd0, 4'd0, 4'd5, 4'd5, 4'd10, 4'd10, 4'd15};
    for (int f = 0; f < nframes; f++) begin
      e.sel  = (f < 7) ? old_sel : req_late;
      e.lvl  = lvl_tab[f];
      e.busy = (f < 13);
      e.done = (f == 13);
      sb_q.push_back(e);
    end
    req = req0;
    for (int f = 0; f < nframes; f++) begin
      if (f == 4) req = req_late;
      frame(1'b0, $sformatf("%s.F%0d", tag, f));
    end
  endtask

  initial begin
    exp_t idle;
    rst_n = 1'b0; rst_n6 = 1'b0;
    vsync = 1'b0; vsync6 = 1'b1;
    req = 2'd0; req6 = 2'd1;
    idle = '{sel: 2'd0, lvl: 4'd15, busy: 1'b0, done: 1'b0};

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    chk_all("reset", obs(1'b0), idle);
    chk_all("reset6", obs(1'b1), idle);
    rst_n = 1'b1; rst_n6 = 1'b1;

    // vsync held high across reset release gives no tick.
    repeat (5) @(negedge clk);
    chk("vsync_high_release.busy", 8'(busy6), 8'd0);
    vsync6 = 1'b0;

    // Test 1: idle frames with START requested.
    for (int f = 0; f < 3; f++) begin
      sb_q.push_back(idle);
      frame(1'b0, $sformatf("idle.F%0d", f));
    end
    // A request between frame starts is not acted on.
    req = 2'd1;
    repeat (3) @(negedge clk);
    chk("between_frames.busy", 8'(busy), 8'd0);
    req = 2'd0;
    sb_q.push_back(idle);
    frame(1'b0, "idle.F3");

    // Test 2: START -> GK.
    run_default(2'd0, 2'd1, 2'd1, 14, "t2");
    // Test 3: GK, request SHOOTER then END mid fade-out.
    run_default(2'd1, 2'd2, 2'd3, 14, "t3");
    // Test 4: END, request GK then back to END: same-screen fade.
    run_default(2'd3, 2'd1, 2'd3, 14, "t4");

    // Test 5: async reset mid fade-in (level 5), between clock edges.
    run_default(2'd3, 2'd2, 2'd2, 10, "t5");
    chk("t5.sb_drained", 8'(sb_q.size()), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("t5.async_reset", obs(1'b0), idle);
    repeat (2) @(negedge clk);
    chk("t5.reset_hold.done", 8'(done), 8'd0);
    req = 2'd0;
    rst_n = 1'b1;
    sb_q.push_back(idle);
    frame(1'b0, "t5.after");

    // Test 6: FRAMES_PER_STEP=1, FADE_STEP=4, START -> GK.
    begin
      logic [3:0] t6 [10];
      exp_t e;
      t6 = '{4'd15, 4'd11, 4'd7, 4'd3, 4'd0, 4'd0, 4'd4, 4'd8, 4'd12, 4'd15};
      for (int f = 0; f < 10; f++) begin
        e.sel  = (f < 5) ? 2'd0 : 2'd1;
        e.lvl  = t6[f];
        e.busy = (f < 9);
        e.done = (f == 9);
        sb_q.push_back(e);
      end
      for (int f = 0; f < 10; f++) frame(1'b1, $sformatf("t6.F%0d", f));
    end
    chk("final.sb_drained", 8'(sb_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_transition_ctl.md
Name: screen_transition_ctl

Overview:
Frame-synchronous controller that sequences the background/overlay draw datapath between game screens: start, goalkeeper, shooter and end.
- Accepts the screen requested by the game FSM.
- Fades the current screen to black over whole frames, swaps the screen select during a black frame, then fades back in.
- Drives the background mux select and the brightness level used by the downstream RGB fade stage.

Parameters:
FRAMES_PER_STEP, 2, number of frame starts per brightness step (1..15)
FADE_STEP, 5, brightness decrement/increment per step (1..15); result saturates at 0 and 15

Ports:
clk  input  1  system pixel clock
rst_n  input  1  asynchronous active-low reset
vsync  input  1  vertical sync from the timing generator; a rising edge is a frame start
screen_req  input  2  requested screen (screen_t: 0 START, 1 GK, 2 SHOOTER, 3 END); level, may change at any time
screen_sel  output  2  screen currently rendered; drives the background mux
fade_level  output  4  brightness, 15 = full, 0 = black
busy  output  1  high in any state other than SHOW
switch_done  output  1  one-cycle pulse when a transition completes

Behaviour:
Reset (async, rst_n low):
- state SHOW, screen_sel START, fade_level 15, busy 0, switch_done 0.
- Frame counter 0; vsync_q 0.
- Reset mid-transition aborts immediately to these values.

Frame tick:
- vsync_q registers vsync.
- frame_start = vsync & ~vsync_q.
- vsync already high at reset release produces no tick.
- All outputs are registered; they update on the clock edge where frame_start is true, i.e. visible 1 clk after the first sampled-high vsync.

Frame counter:
- Active only in FADE_OUT and FADE_IN.
- Cleared on entry to either state.
- On frame_start: if cnt == FRAMES_PER_STEP-1, then step the level and clear cnt; otherwise cnt+1.
- Level arithmetic is done 5 bits wide, then clamped to 0..15.

States:
- SHOW: on frame_start with screen_req != screen_sel → FADE_OUT. Requests are ignored between frame starts.
- FADE_OUT: each step does level -= FADE_STEP (clamped at 0). On the step that reaches 0 → SWAP.
- SWAP: level held at 0. On the next frame_start, screen_sel <= screen_req (the latest value, not the value that started the transition) → FADE_IN. If screen_req now equals the old screen_sel, fade in on the same screen (no glitch, still one black frame).
- FADE_IN: each step does level += FADE_STEP (clamped at 15). On the step reaching 15 → SHOW, with switch_done pulsed in the same cycle.
- screen_req changes during FADE_IN are not acted on until SHOW re-evaluates them at the next frame_start.

Busy: busy = (state != SHOW), registered together with the state.

Default-parameter timing: a transition spans exactly 13 frame starts after the triggering one:
- 6 to fade out (levels 10, 5, 0)
- 1 SWAP
- 6 to fade in (5, 10, 15)

Decomposition:
- Shared package (game/draw package): screen_t enum (START, GK, SHOOTER, END), FADE_MAX = 4'd15, FADE_MIN = 4'd0.
- ctl_state_t enum (SHOW, FADE_OUT, SWAP, FADE_IN) is local to the module.
- One natural sub-module, frame_tick: vsync edge detect plus the FRAMES_PER_STEP divider with clear input, outputting frame_start and step_tick.
- The RGB scaling itself lives downstream and is out of scope.

Test Plan:
1. Reset then idle vsync with screen_req = START → screen_sel 0, fade_level 15, busy 0, switch_done never pulses.
2. Defaults, screen_req = GK before frame start F0 → busy at F0. Levels:
   - 15 until F2, 10 at F2, 5 at F4, 0 at F6 (SWAP)
   - screen_sel = 1 at F7
   - 5 at F9, 10 at F11, 15 at F13, with a single switch_done pulse and busy 0 at F13
3. During FADE_OUT (after F3) change screen_req to END → at F7 screen_sel = 3; the fade profile is identical to test 2.
4. During FADE_OUT, return screen_req to START → at F7 screen_sel stays 0, fade-in completes, switch_done pulses at F13.
5. Assert rst_n low asynchronously mid FADE_IN (level 5, between clock edges) → outputs return to reset values before the next clk edge; no switch_done.
6. FRAMES_PER_STEP = 1, FADE_STEP = 4 → fade-out levels 11, 7, 3, 0 (clamped), fade-in 4, 8, 12, 15 (clamped). vsync held high across reset release gives no tick until a new rising edge.
